mem_access_unit: RTL and testbench

Sequencer between the memory address decoder and the two synchronous data RAMs: RAM0 is 64 words, RAM1 is 254 000 words. It takes decoded requests (select, write enables, local address, clear strobe), drives registered RAM ports and waits out RAM read latency. It returns read data with a valid pulse and runs the clear sequence triggered by the decoder's reset strobe, zeroing RAM0. It stalls the processor memory stage through a ready/busy handshake.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mau_clear_seq.sv | 30 +++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access unit and its clear sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CLEAR
  } mau_state_t;

  localparam int RAM0_WORDS = 64;
  localparam int RAM1_WORDS = 254000;
  localparam int RAM1_BASE  = 64;
  localparam int CLR_ADDR   = 254064;

  localparam logic [1:0] WEN_RAM0 = 2'b01;
  localparam logic [1:0] WEN_RAM1 = 2'b10;

endpackage

// File: rtl/mau_clear_seq.sv
// RAM0 clear address counter: restarts on start, advances one word per step, wraps after the last word.
module mau_clear_seq
  import mem_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          step,
  output logic [AW-1:0] next_addr,
  output logic          done
);

  logic [AW-1:0] clr_cnt;

  assign done      = (clr_cnt == AW'(RAM0_WORDS - 1));
  assign next_addr = clr_cnt + AW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt <= '0;
    end else if (start) begin
      clr_cnt <= '0;
    end else if (step) begin
      clr_cnt <= done ? '0 : next_addr;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sequencer between the address decoder and the two data RAMs: registered RAM ports,
// read-latency wait, RAM0 clear sequence and a ready/busy handshake to the memory stage.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 2,
  parameter int RAM0_AW = 6,
  parameter int RAM1_AW = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ReqValid,
  output logic               ReqReady,
  input  logic               MemWrite,
  input  logic               DSel,
  input  logic               Clr,
  input  logic [1:0]         WEn,
  input  logic [31:0]        dAddr,
  input  logic [DATA_W-1:0]  WriteData,
  output logic [RAM0_AW-1:0] Ram0Addr,
  output logic               Ram0WE,
  output logic [DATA_W-1:0]  Ram0WData,
  input  logic [DATA_W-1:0]  Ram0RData,
  output logic [RAM1_AW-1:0] Ram1Addr,
  output logic               Ram1WE,
  output logic [DATA_W-1:0]  Ram1WData,
  input  logic [DATA_W-1:0]  Ram1RData,
  output logic [DATA_W-1:0]  ReadData,
  output logic               RdValid,
  output logic               Busy
);

  mau_state_t         state_q, state_d;
  logic [2:0]         lat_cnt;
  logic               sel_q;
  logic               accept, acc_clr, acc_wr, acc_rd;
  logic               in_clear;
  logic [RAM0_AW-1:0] clr_next;
  logic               clr_done;
  logic               unused_addr_bits;

  assign ReqReady = (state_q == IDLE);
  assign Busy     = (state_q != IDLE);
  assign in_clear = (state_q == CLEAR);
  assign accept   = ReqValid & ReqReady;
  assign acc_clr  = accept & Clr;
  assign acc_wr   = accept & ~Clr & MemWrite;
  assign acc_rd   = accept & ~Clr & ~MemWrite;

  // Address bits above each RAM's width carry no meaning here.
  assign unused_addr_bits = ^dAddr[31:RAM1_AW];

  mau_clear_seq #(
    .AW(RAM0_AW)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .start    (acc_clr),
    .step     (in_clear),
    .next_addr(clr_next),
    .done     (clr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (acc_clr)     state_d = CLEAR;
        else if (acc_rd) state_d = READ;
      end
      READ:    if (lat_cnt == 3'd0) state_d = IDLE;
      CLEAR:   if (clr_done)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM port registers, read latency counter and load return
  always_ff @(posedge clk) begin
    if (reset) begin
      Ram0Addr  <= '0;
      Ram0WE    <= 1'b0;
      Ram0WData <= '0;
      Ram1Addr  <= '0;
      Ram1WE    <= 1'b0;
      Ram1WData <= '0;
      ReadData  <= '0;
      RdValid   <= 1'b0;
      lat_cnt   <= 3'd0;
      sel_q     <= 1'b0;
    end else begin
      Ram0WE  <= 1'b0;
      Ram1WE  <= 1'b0;
      RdValid <= 1'b0;

      if (acc_clr) begin
        Ram0Addr  <= '0;
        Ram0WE    <= 1'b1;
        Ram0WData <= '0;
      end else if (acc_wr) begin
        // WEn of 00 or 11 matches neither target, so nothing is written.
        Ram0Addr  <= dAddr[RAM0_AW-1:0];
        Ram1Addr  <= dAddr[RAM1_AW-1:0];
        Ram0WData <= WriteData;
        Ram1WData <= WriteData;
        Ram0WE    <= (WEn == WEN_RAM0);
        Ram1WE    <= (WEn == WEN_RAM1);
      end else if (acc_rd) begin
        Ram0Addr <= dAddr[RAM0_AW-1:0];
        Ram1Addr <= dAddr[RAM1_AW-1:0];
        sel_q    <= DSel;
        lat_cnt  <= 3'(RD_LAT);
      end

      if (state_q == READ) begin
        if (lat_cnt == 3'd0) begin
          ReadData <= sel_q ? Ram1RData : Ram0RData;
          RdValid  <= 1'b1;
        end else begin
          lat_cnt <= lat_cnt - 3'd1;
        end
      end

      if (in_clear && !clr_done) begin
        Ram0Addr  <= clr_next;
        Ram0WE    <= 1'b1;
        Ram0WData <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with RAM models and a queue-based scoreboard.
module tb_mem_access_unit;

  localparam int DATA_W  = 32;
  localparam int RD_LAT  = 2;
  localparam int RAM0_AW = 6;
  localparam int RAM1_AW = 18;

  logic               clk = 1'b0;
  logic               reset;
  logic               ReqValid, ReqReady, MemWrite, DSel, Clr;
  logic [1:0]         WEn;
  logic [31:0]        dAddr;
  logic [DATA_W-1:0]  WriteData;
  logic [RAM0_AW-1:0] Ram0Addr;
  logic               Ram0WE;
  logic [DATA_W-1:0]  Ram0WData, Ram0RData;
  logic [RAM1_AW-1:0] Ram1Addr;
  logic               Ram1WE;
  logic [DATA_W-1:0]  Ram1WData, Ram1RData;
  logic [DATA_W-1:0]  ReadData;
  logic               RdValid, Busy;

  mem_access_unit #(
    .DATA_W(DATA_W), .RD_LAT(RD_LAT), .RAM0_AW(RAM0_AW), .RAM1_AW(RAM1_AW)
  ) dut (
    .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .MemWrite(MemWrite), .DSel(DSel), .Clr(Clr), .WEn(WEn), .dAddr(dAddr),
    .WriteData(WriteData),
    .Ram0Addr(Ram0Addr), .Ram0WE(Ram0WE), .Ram0WData(Ram0WData), .Ram0RData(Ram0RData),
    .Ram1Addr(Ram1Addr), .Ram1WE(Ram1WE), .Ram1WData(Ram1WData), .Ram1RData(Ram1RData),
    .ReadData(ReadData), .RdValid(RdValid), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: write on WE, read data appears RD_LAT cycles after the address
  logic [DATA_W-1:0] ram0 [0:63];
  logic [DATA_W-1:0] ram1 [0:262143];
  logic [DATA_W-1:0] p0 [0:RD_LAT-1];
  logic [DATA_W-1:0] p1 [0:RD_LAT-1];

  always @(posedge clk) begin
    if (Ram0WE) ram0[Ram0Addr] <= Ram0WData;
    if (Ram1WE) ram1[Ram1Addr] <= Ram1WData;
    p0[0] <= ram0[Ram0Addr];
    p1[0] <= ram1[Ram1Addr];
    for (int i = 1; i < RD_LAT; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign Ram0RData = p0[RD_LAT-1];
  assign Ram1RData = p1[RD_LAT-1];

  int tests = 0;
  int fails = 0;
  logic [63:0] rd_q[$];
  logic [63:0] w0_q[$];
  logic [63:0] w1_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every RdValid / WE pulse must match the next expected entry
  always @(negedge clk) begin
    if (RdValid === 1'b1) begin
      if (rd_q.size() == 0) chk("rd_unexpected_pulse", 64'd1, 64'd0);
      else                  chk("rd_data", 64'(ReadData), rd_q.pop_front());
    end
    if (Ram0WE === 1'b1) begin
      if (w0_q.size() == 0) chk("ram0_unexpected_we", 64'd1, 64'd0);
      else                  chk("ram0_write", {26'd0, Ram0Addr, Ram0WData}, w0_q.pop_front());
    end
    if (Ram1WE === 1'b1) begin
      if (w1_q.size() == 0) chk("ram1_unexpected_we", 64'd1, 64'd0);
      else                  chk("ram1_write", {14'd0, Ram1Addr, Ram1WData}, w1_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for ReqReady, return just after the accepting edge
  task automatic req(input logic wr, input logic clr, input logic dsel, input logic [1:0] wen,
                     input logic [31:0] addr, input logic [31:0] data, output int tacc);
    int n = 0;
    MemWrite = wr; Clr = clr; DSel = dsel; WEn = wen; dAddr = addr; WriteData = data;
    ReqValid = 1'b1;
    while (!ReqReady && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("req_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    tacc = cyc;
    #1;
    ReqValid = 1'b0; Clr = 1'b0; MemWrite = 1'b0; WEn = 2'b00;
  endtask

  task automatic wait_rd(output int n);
    n = 0;
    while (!RdValid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("rdvalid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, n, seen;
    reset = 1'b1; ReqValid = 1'b0; MemWrite = 1'b0; DSel = 1'b0; Clr = 1'b0;
    WEn = 2'b00; dAddr = '0; WriteData = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_ready", 64'(ReqReady), 64'd1);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_rdvalid", 64'(RdValid), 64'd0);
    chk("rst_readdata", 64'(ReadData), 64'd0);
    chk("rst_we", {62'd0, Ram0WE, Ram1WE}, 64'd0);
    chk("rst_addr", {26'd0, Ram0Addr, 14'd0, Ram1Addr}, 64'd0);

    // RAM0 writes, then two back-to-back loads
    w0_q.push_back({32'd5, 32'hDEADBEEF});
    req(1'b1, 1'b0, 1'b0, 2'b01, 32'd5, 32'hDEADBEEF, t0);
    w0_q.push_back({32'd36, 32'h11});
    req(1'b1, 1'b0, 1'b0, 2'b01, 32'd36, 32'h11, t0);
    rd_q.push_back(64'hDEADBEEF);
    req(1'b0, 1'b0, 1'b0, 2'b00, 32'd5, 32'd0, t1);
    chk("read_ready_busy", {62'd0, ReqReady, Busy}, 64'b01);
    wait_rd(n);
    chk("read_latency", 64'(n), 64'(RD_LAT + 1));
    chk("read_data_direct", 64'(ReadData), 64'hDEADBEEF);
    chk("ready_with_rdvalid", 64'(ReqReady), 64'd1);
    rd_q.push_back(64'h11);
    req(1'b0, 1'b0, 1'b0, 2'b00, 32'd36, 32'd0, t2);
    chk("load_spacing", 64'(t2 - t1), 64'(RD_LAT + 2));
    wait_rd(n);

    // Back-to-back RAM1 writes
    w1_q.push_back({32'd0, 32'hA1});
    w1_q.push_back({32'd1, 32'hA2});
    w1_q.push_back({32'h3E02F, 32'hA3});
    req(1'b1, 1'b0, 1'b1, 2'b10, 32'd0, 32'hA1, t0);
    chk("b2b_ready0", 64'(ReqReady), 64'd1);
    req(1'b1, 1'b0, 1'b1, 2'b10, 32'd1, 32'hA2, t1);
    chk("b2b_ready1", 64'(ReqReady), 64'd1);
    req(1'b1, 1'b0, 1'b1, 2'b10, 32'd253999, 32'hA3, t2);
    chk("b2b_rate", 64'(t2 - t0), 64'd2);
    w1_q.push_back({32'd100, 32'h22});
    req(1'b1, 1'b0, 1'b1, 2'b10, 32'd100, 32'h22, t0);

    // RAM1 read selected by latched sel while DSel flips
    rd_q.push_back(64'h22);
    req(1'b0, 1'b0, 1'b1, 2'b00, 32'd100, 32'd0, t0);
    DSel = 1'b0;
    wait_rd(n);
    chk("sel_latched", 64'(ReadData), 64'h22);

    // Clear with a read held pending during Busy
    w0_q.push_back({32'd63, 32'h5A5A5A5A});
    req(1'b1, 1'b0, 1'b0, 2'b01, 32'd63, 32'h5A5A5A5A, t0);
    for (int k = 0; k < 64; k++) w0_q.push_back({32'(k), 32'd0});
    req(1'b1, 1'b1, 1'b1, 2'b10, 32'd9, 32'hFFFFFFFF, t0);
    rd_q.push_back(64'd0);
    MemWrite = 1'b0; Clr = 1'b0; DSel = 1'b0; dAddr = 32'hFFFFFFFF; ReqValid = 1'b1;
    n = 0; seen = 0;
    while (Busy && n < 100) begin
      if (RdValid) seen++;
      tick();
      n++;
    end
    chk("clear_busy_cycles", 64'(n), 64'd64);
    chk("clear_no_accept", 64'(seen), 64'd0);
    chk("clear_ready_after", 64'(ReqReady), 64'd1);
    tick();
    ReqValid = 1'b0;
    wait_rd(n);
    chk("read_after_clear", 64'(ReadData), 64'd0);

    // No-op writes
    req(1'b1, 1'b0, 1'b0, 2'b00, 32'd7, 32'hFFFF, t0);
    chk("noop00", {60'd0, Ram0WE, Ram1WE, ReqReady, Busy}, 64'b0010);
    req(1'b1, 1'b0, 1'b0, 2'b11, 32'd7, 32'hFFFF, t0);
    chk("noop11", {60'd0, Ram0WE, Ram1WE, ReqReady, Busy}, 64'b0010);
    tick();

    // Reset at clear step 10 leaves later words untouched
    w0_q.push_back({32'd20, 32'h77});
    req(1'b1, 1'b0, 1'b0, 2'b01, 32'd20, 32'h77, t0);
    for (int k = 0; k < 10; k++) w0_q.push_back({32'(k), 32'd0});
    req(1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0, t0);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    chk("rstclr_state", {60'd0, Ram0WE, Ram1WE, ReqReady, Busy}, 64'b0010);
    chk("rstclr_addr", 64'(Ram0Addr), 64'd0);
    reset = 1'b0;
    rd_q.push_back(64'h77);
    req(1'b0, 1'b0, 1'b0, 2'b00, 32'd20, 32'd0, t0);
    wait_rd(n);

    // Reset one cycle into a read
    req(1'b0, 1'b0, 1'b1, 2'b00, 32'd1, 32'd0, t0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstrd_readdata", 64'(ReadData), 64'd0);
    chk("rstrd_state", {61'd0, RdValid, ReqReady, Busy}, 64'b010);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (RdValid) seen++;
      tick();
    end
    chk("rstrd_no_pulse", 64'(seen), 64'd0);

    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
    chk("w0_q_empty", 64'(w0_q.size()), 64'd0);
    chk("w1_q_empty", 64'(w1_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
